// File: rtl/snake_pkg.sv
// Shared types and default frame counts for the snake screen logic.
package snake_pkg;

  // Screen shown by the draw mux.
  typedef enum logic [2:0] {
    MENU  = 3'd0,
    GAME  = 3'd1,
    WIN   = 3'd2,
    LOSE  = 3'd3,
    DRAW  = 3'd4,
    ERROR = 3'd5
  } game_mode;

  // Outcome reported by the game logic together with game_end.
  typedef enum logic [1:0] {
    RES_WIN  = 2'd0,
    RES_LOSE = 2'd1,
    RES_DRAW = 2'd2
  } game_result_t;

  // Default frame counts for the mode sequencer.
  localparam int HOLD_FRAMES_DEF      = 60;
  localparam int TIMEOUT_FRAMES_DEF   = 600;
  localparam int ERR_CLEAR_FRAMES_DEF = 30;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_result(input game_mode m);
    return (m == WIN) || (m == LOSE) || (m == DRAW);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing stream shared between the screen controller and the draw block.
interface vga_if;
  logic vblnk;

  modport in  (input  vblnk);
  modport out (output vblnk);
endinterface

// File: rtl/mode_sequencer_frame_tick_gen.sv
// Frame boundary detector: one-cycle frame_tick after each rising edge of vblnk.
// The edge register resets high, so a vblnk that is already high when reset
// releases does not count as a boundary; a real 0->1 transition is required.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic frame_tick
);

  logic vblnk_reg;

  // Remember previous vblnk and register the rising-edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_reg  <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vblnk_reg  <= vblnk;
      frame_tick <= vblnk & ~vblnk_reg;
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Screen mode sequencer: latches start/game_end/confirm events and applies
// mode changes only on frame ticks, so each frame shows a single screen.
// Optional feature macro: RESULT_TIMEOUT_EN (result screens time out to MENU).
//
// Frame counting: frame_cnt is the number of completed frames shown in the
// current mode. At a tick the decision uses the count including the frame
// that just ended, so a result screen entered at tick 0 can exit at tick
// HOLD_FRAMES, and ERROR exits on the ERR_CLEAR_FRAMES-th clean tick.
// Any tick that changes the mode (or sees link_err) flushes every pending
// event, including pulses arriving in that same cycle.
module mode_sequencer
  import snake_pkg::*;
#(
  parameter int HOLD_FRAMES      = HOLD_FRAMES_DEF,
  parameter int TIMEOUT_FRAMES   = TIMEOUT_FRAMES_DEF,
  parameter int ERR_CLEAR_FRAMES = ERR_CLEAR_FRAMES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  vga_if.in            vga_in,
  input  logic         start,
  input  logic         confirm,
  input  logic         game_end,
  input  game_result_t game_result,
  input  logic         link_err,
  output game_mode     mode,
  output logic         game_en,
  output logic         frame_tick
);

  localparam int FRAME_MAX = max_int(HOLD_FRAMES, TIMEOUT_FRAMES);
  localparam int CNT_W     = $clog2(FRAME_MAX + 1);
  localparam int CLR_W     = $clog2(ERR_CLEAR_FRAMES + 1);

  localparam logic [CNT_W-1:0] FRAME_MAX_C = CNT_W'(FRAME_MAX);
  localparam logic [CNT_W-1:0] HOLD_C      = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT_FRAMES);
  localparam logic [CLR_W-1:0] CLR_C       = CLR_W'(ERR_CLEAR_FRAMES);

`ifdef RESULT_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic               start_pend;
  logic               end_pend;
  logic               conf_pend;
  game_result_t       res_q;
  logic [CNT_W-1:0]   frame_cnt;
  logic [CLR_W-1:0]   clr_cnt;

  logic [CNT_W-1:0]   cnt_now;
  logic [CLR_W-1:0]   clr_now;
  game_mode           mode_next;
  logic               flush;

  frame_tick_gen u_tick (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vga_in.vblnk),
    .frame_tick (frame_tick)
  );

  // Counter values including the current tick, and the next mode decision.
  always_comb begin
    cnt_now   = (frame_cnt == FRAME_MAX_C) ? frame_cnt : frame_cnt + 1'b1;
    clr_now   = link_err ? '0 : ((clr_cnt == CLR_C) ? clr_cnt : clr_cnt + 1'b1);
    mode_next = mode;
    if (frame_tick) begin
      if (link_err) begin
        mode_next = ERROR;
      end else begin
        case (mode)
          MENU: if (start_pend) mode_next = GAME;
          GAME: begin
            if (end_pend) begin
              case (res_q)
                RES_WIN:  mode_next = WIN;
                RES_LOSE: mode_next = LOSE;
                default:  mode_next = DRAW;
              endcase
            end
          end
          WIN, LOSE, DRAW: begin
            if ((cnt_now >= HOLD_C) && conf_pend) mode_next = MENU;
            if (TIMEOUT_ON && (cnt_now == TIMEOUT_C)) mode_next = MENU;
          end
          ERROR: if (clr_now == CLR_C) mode_next = MENU;
          default: mode_next = MENU;
        endcase
      end
    end
    flush = frame_tick && (link_err || (mode_next != mode));
  end

  // Mode/output registers, event latches and frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode       <= MENU;
      game_en    <= 1'b0;
      start_pend <= 1'b0;
      end_pend   <= 1'b0;
      conf_pend  <= 1'b0;
      res_q      <= RES_WIN;
      frame_cnt  <= '0;
      clr_cnt    <= '0;
    end else begin
      mode    <= mode_next;
      game_en <= (mode_next == GAME);

      if (flush) begin
        start_pend <= 1'b0;
        end_pend   <= 1'b0;
        conf_pend  <= 1'b0;
      end else begin
        if (start && (mode == MENU)) start_pend <= 1'b1;
        if (game_end) begin
          end_pend <= 1'b1;
          res_q    <= game_result;
        end
        if (confirm && is_result(mode)) conf_pend <= 1'b1;
      end

      if (mode_next != mode) frame_cnt <= '0;
      else if (frame_tick)   frame_cnt <= cnt_now;

      if (link_err)        clr_cnt <= '0;
      else if (frame_tick) clr_cnt <= clr_now;
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// Testbench for mode_sequencer: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a frame-level model.
module tb_mode_sequencer;
  import snake_pkg::*;

`ifdef RESULT_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif
  localparam int HOLD = 60;
  localparam int TMO  = 600;
  localparam int CLR  = 30;
  localparam int FMAX = 600;
  localparam int FRAME_LEN = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, confirm = 1'b0, game_end = 1'b0, link_err = 1'b0;
  game_result_t game_result = RES_WIN;
  game_mode mode;
  logic game_en, frame_tick;

  int tests = 0;
  int fails = 0;
  int pos = 0;

  vga_if vga ();

  mode_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .vga_in      (vga),
    .start       (start),
    .confirm     (confirm),
    .game_end    (game_end),
    .game_result (game_result),
    .link_err    (link_err),
    .mode        (mode),
    .game_en     (game_en),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  // Free-running frame: vblnk high for the last 4 clocks of every 16.
  initial begin
    vga.vblnk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pos = (pos + 1) % FRAME_LEN;
      vga.vblnk = (pos >= 12);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  game_mode     m_mode = MENU;
  logic         m_tick = 1'b0;
  logic         m_gen  = 1'b0;
  logic         m_prev_vb = 1'b1;
  bit           m_sp, m_ep, m_cp;
  game_result_t m_res = RES_WIN;
  int           m_fcnt, m_ccnt;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = MENU; m_tick = 0; m_gen = 0; m_prev_vb = 1;
      m_sp = 0; m_ep = 0; m_cp = 0; m_res = RES_WIN; m_fcnt = 0; m_ccnt = 0;
    end else begin
      automatic bit       was_tick = m_tick;
      automatic game_mode nm = m_mode;
      automatic int       cnow = (m_fcnt + 1 > FMAX) ? FMAX : m_fcnt + 1;
      automatic int       clnow = link_err ? 0 : ((m_ccnt + 1 > CLR) ? CLR : m_ccnt + 1);
      automatic bit       res_screen = (m_mode == WIN) || (m_mode == LOSE) || (m_mode == DRAW);
      m_tick = vga.vblnk && !m_prev_vb;
      m_prev_vb = vga.vblnk;
      if (was_tick) begin
        if (link_err) nm = ERROR;
        else if (m_mode == MENU && m_sp) nm = GAME;
        else if (m_mode == GAME && m_ep)
          nm = (m_res == RES_WIN) ? WIN : (m_res == RES_LOSE) ? LOSE : DRAW;
        else if (res_screen && ((cnow >= HOLD && m_cp) || (TIMEOUT_ON && cnow == TMO))) nm = MENU;
        else if (m_mode == ERROR && clnow == CLR) nm = MENU;
      end
      if ((was_tick && link_err) || nm != m_mode) begin
        m_sp = 0; m_ep = 0; m_cp = 0;
      end else begin
        if (start && m_mode == MENU) m_sp = 1;
        if (game_end) begin m_ep = 1; m_res = game_result; end
        if (confirm && res_screen) m_cp = 1;
      end
      if (nm != m_mode) m_fcnt = 0;
      else if (was_tick) m_fcnt = cnow;
      if (link_err) m_ccnt = 0;
      else if (was_tick) m_ccnt = clnow;
      m_mode = nm;
      m_gen = (nm == GAME);
    end
  end

  // Compare DUT outputs with the model on every cycle.
  always @(negedge clk) begin
    chk("model_mode", int'(mode), int'(m_mode));
    chk("model_game_en", int'(game_en), int'(m_gen));
    chk("model_frame_tick", int'(frame_tick), int'(m_tick));
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input int which, input game_result_t r);
    @(posedge clk); #1;
    case (which)
      0: start = 1'b1;
      1: confirm = 1'b1;
      default: begin game_end = 1'b1; game_result = r; end
    endcase
    @(posedge clk); #1;
    start = 1'b0; confirm = 1'b0; game_end = 1'b0;
  endtask

  task automatic set_link(input logic v);
    @(posedge clk); #1;
    link_err = v;
  endtask

  // Wait for a frame tick, then one more cycle so mode has updated.
  task automatic next_frame();
    bit seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL frame_tick_timeout: got none, expected a tick within 64 cycles at %0t", $time);
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset values, mid-frame reset.
    repeat (3) @(negedge clk);
    chk("reset_mode", int'(mode), int'(MENU));
    chk("reset_game_en", int'(game_en), 0);
    chk("reset_frame_tick", int'(frame_tick), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Start mid-frame: MENU until the tick, GAME one cycle after it.
    wait (pos == 3);
    pulse(0, RES_WIN);
    begin
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        chk("start_wait_menu", int'(mode), int'(MENU));
        if (frame_tick) seen = 1;
      end
      chk("start_tick_seen", int'(seen), 1);
      @(negedge clk);
      chk("start_game_mode", int'(mode), int'(GAME));
      chk("start_game_en", int'(game_en), 1);
    end

    // LOSE with early confirm, MENU exactly at frame 60.
    pulse(2, RES_LOSE);
    next_frame();
    chk("lose_entry", int'(mode), int'(LOSE));
    chk("lose_game_en", int'(game_en), 0);
    for (int n = 1; n <= HOLD; n++) begin
      next_frame();
      chk("lose_hold", int'(mode), int'((n == HOLD) ? MENU : LOSE));
      if (n == 10) pulse(1, RES_WIN);
    end

    // WIN, link error, interrupted clear window.
    pulse(0, RES_WIN);
    next_frame();
    chk("err_game", int'(mode), int'(GAME));
    pulse(2, RES_WIN);
    next_frame();
    chk("err_win", int'(mode), int'(WIN));
    set_link(1'b1);
    next_frame();
    chk("err_entry", int'(mode), int'(ERROR));
    set_link(1'b0);
    for (int n = 1; n <= CLR - 1; n++) begin
      next_frame();
      chk("err_first_window", int'(mode), int'(ERROR));
    end
    set_link(1'b1);
    next_frame();
    chk("err_glitch", int'(mode), int'(ERROR));
    set_link(1'b0);
    for (int n = 1; n <= CLR; n++) begin
      next_frame();
      chk("err_clear", int'(mode), int'((n == CLR) ? MENU : ERROR));
    end

    // game_end(DRAW) and link_err together: ERROR, result lost.
    pulse(0, RES_WIN);
    next_frame();
    pulse(2, RES_DRAW);
    set_link(1'b1);
    next_frame();
    chk("draw_err_entry", int'(mode), int'(ERROR));
    set_link(1'b0);
    for (int n = 1; n <= CLR; n++) next_frame();
    chk("draw_err_exit", int'(mode), int'(MENU));
    pulse(0, RES_WIN);
    next_frame();
    next_frame();
    chk("draw_result_lost", int'(mode), int'(GAME));

    // Result timeout (or indefinite wait without the macro).
    pulse(2, RES_WIN);
    next_frame();
    chk("tmo_win", int'(mode), int'(WIN));
    for (int n = 1; n <= 1000; n++) begin
      next_frame();
      if (TIMEOUT_ON && n == TMO - 1) chk("tmo_before", int'(mode), int'(WIN));
      if (TIMEOUT_ON && n == TMO) begin
        chk("tmo_expire", int'(mode), int'(MENU));
        break;
      end
      if (!TIMEOUT_ON && n == 1000) chk("tmo_still_win", int'(mode), int'(WIN));
    end
    pulse(1, RES_WIN);
    next_frame();
    chk("tmo_back_menu", int'(mode), int'(MENU));

    // Stale start during GAME is ignored.
    pulse(0, RES_WIN);
    next_frame();
    pulse(0, RES_WIN);
    pulse(2, RES_WIN);
    next_frame();
    chk("stale_win", int'(mode), int'(WIN));
    pulse(1, RES_WIN);
    begin
      int exit_n = 0;
      for (int n = 1; n <= HOLD + 5 && exit_n == 0; n++) begin
        next_frame();
        if (mode == MENU) exit_n = n;
      end
      chk("stale_exit_frame", exit_n, HOLD);
    end
    next_frame();
    chk("stale_stays_menu", int'(mode), int'(MENU));
    next_frame();
    chk("stale_stays_menu2", int'(mode), int'(MENU));

    // vblnk held high across reset: no tick until a fresh rising edge.
    wait (pos == 12);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("vb_high_no_tick", int'(frame_tick), 0);
    @(negedge clk);
    chk("vb_high_no_tick2", int'(frame_tick), 0);
    next_frame();
    chk("vb_after_reset", int'(mode), int'(MENU));

    // Randomized traffic, checked by the model.
    for (int c = 0; c < 1500 * FRAME_LEN; c++) begin
      @(posedge clk); #1;
      rst      = ($urandom_range(0, 4999) == 0);
      start    = !start    && ($urandom_range(0, 39) == 0);
      confirm  = !confirm  && ($urandom_range(0, 39) == 0);
      game_end = !game_end && ($urandom_range(0, 59) == 0);
      game_result = game_result_t'($urandom_range(0, 2));
      if (link_err) link_err = ($urandom_range(0, 39) != 0);
      else          link_err = ($urandom_range(0, 2999) == 0);
    end
    @(posedge clk); #1;
    rst = 0; start = 0; confirm = 0; game_end = 0; link_err = 0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
